fifo_burst_reader: RTL and testbench

- Read-side master for the team's synchronous first-word-fall-through FIFO.
- On a start command it pops exactly len_i words from the FIFO and forwards them in order on a valid/ready output stream.
- Output stage is a 2-entry skid buffer, so there is no combinational path from m_ready_i to fifo_rd_valid_o.
- Sits between a FIFO and any stream consumer (DMA write port, serializer); signals completion with a one-cycle done pulse.

---
 rtl/fifo_burst_reader.sv | 92 +++++++++
 tb/tb_fifo_burst_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side master for a first-word-fall-through FIFO: pops a fixed-length burst
// and forwards it through a 2-entry skid buffer onto a valid/ready stream.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  remaining_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head, tail;
  logic                  pop, xfer;

  // Pop depends only on registered state and the FIFO flag, never on m_ready_i.
  assign pop  = (state == RUN) && (remaining != '0) && !fifo_empty_i && (occ != 2'd2);
  assign xfer = (occ != 2'd0) && m_ready_i;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start_i) state_nxt = (len_i == '0) ? DONE : RUN;
      RUN:   if (pop && (remaining == LEN_WIDTH'(1))) state_nxt = DRAIN;
      DRAIN: if ((occ == 2'd1) && xfer) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start_i) remaining <= len_i;
      else if (pop)                   remaining <= remaining - LEN_WIDTH'(1);
    end
  end

  // Skid buffer: head drives the stream, tail only fills while head is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({pop, xfer})
        2'b10: begin
          if (occ == 2'd0) head <= fifo_data_i;
          else             tail <= fifo_data_i;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) head <= fifo_data_i;
          else begin
            head <= tail;
            tail <= fifo_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o          = (state != IDLE);
  assign done_o          = (state == DONE);
  assign remaining_o     = remaining;
  assign fifo_rd_valid_o = pop;
  assign m_valid_o       = (occ != 2'd0);
  assign m_data_o        = head;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: array-backed FIFO model, stream scoreboard and a
// burst-level reference model checked every cycle, plus directed and random bursts.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o, fifo_empty_i, fifo_rd_valid_o, m_valid_o;
  logic [LW-1:0] remaining_o;
  logic [DW-1:0] fifo_data_i, m_data_o;
  logic          m_ready_i = 1'b1;
  logic          starve = 1'b0;

  int total = 0;
  int bad   = 0;

  // FIFO model
  logic [DW-1:0] mem [0:1023];
  logic [9:0]    rd_ptr = '0;
  logic [9:0]    wr_ptr = '0;

  assign fifo_data_i  = mem[rd_ptr];
  assign fifo_empty_i = (rd_ptr == wr_ptr) || starve;

  always @(posedge clk)
    if (fifo_rd_valid_o && !fifo_empty_i) rd_ptr <= rd_ptr + 10'd1;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .remaining_o(remaining_o),
    .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
    .fifo_rd_valid_o(fifo_rd_valid_o), .m_data_o(m_data_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Burst-level reference: words owed, words held, done owed next cycle.
  bit         m_active = 0, m_done = 0, hold_v = 0;
  int         m_rem = 0, m_pend = 0, deliv = 0;
  logic [9:0] dptr = '0;
  logic [DW-1:0] hold_d = '0;

  always @(negedge clk) begin
    bit pop, xfer, nd;
    if (rst) begin
      m_active = 0; m_rem = 0; m_pend = 0; m_done = 0; hold_v = 0;
      dptr = rd_ptr + ((fifo_rd_valid_o === 1'b1 && !fifo_empty_i) ? 10'd1 : 10'd0);
    end else begin
      chk("busy", busy_o, m_active || m_done);
      chk("done", done_o, m_done);
      chk("m_valid", m_valid_o, m_pend != 0);
      chk("remaining", remaining_o, m_rem);
      chk("pop", fifo_rd_valid_o, m_active && m_rem != 0 && !fifo_empty_i && m_pend != 2);
      if (hold_v) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", m_data_o, hold_d);
      end
      pop  = fifo_rd_valid_o && !fifo_empty_i;
      xfer = m_valid_o && m_ready_i;
      if (xfer) begin
        chk("stream_data", m_data_o, mem[dptr]);
        dptr = dptr + 10'd1;
        deliv++;
      end
      hold_v = m_valid_o && !m_ready_i;
      hold_d = m_data_o;
      nd = 0;
      if (m_active) begin
        if (pop) m_rem--;
        m_pend = m_pend + int'(pop) - int'(xfer);
        if (m_rem == 0 && m_pend == 0) begin
          m_active = 0;
          nd = 1;
        end
      end else if (!m_done && start_i) begin
        m_rem = int'(len_i);
        deliv = 0;
        if (len_i == '0) nd = 1;
        else m_active = 1;
      end
      m_done = nd;
    end
  end

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  task automatic start(input logic [LW-1:0] len);
    start_i = 1'b1;
    len_i   = len;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin ok = 1; break; end
      @(posedge clk); #1;
      if (rnd) begin
        m_ready_i = ($urandom_range(0, 3) != 0);
        starve    = ($urandom_range(0, 3) == 0);
      end
    end
    chk("done_seen", ok, 1);
    m_ready_i = 1'b1;
    starve    = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [9:0] base;
    logic [LW-1:0] len;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_m_data", m_data_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_remaining", remaining_o, 0);
    chk("rst_busy", busy_o, 0);

    // basic burst
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    start(4'd4);
    wait_done(40, 0);
    chk("basic_count", deliv, 4);

    // backpressure
    base = rd_ptr;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    m_ready_i = 1'b0;
    start(4'd6);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_pops", 32'(rd_ptr - base), 2);
    chk("bp_head", m_data_o, mem[base]);
    m_ready_i = 1'b1;
    wait_done(40, 0);
    chk("bp_count", deliv, 6);

    // starved FIFO
    push(8'hA1);
    start(4'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("starve_rem", remaining_o, 2);
    chk("starve_busy", busy_o, 1);
    push(8'hA2);
    push(8'hA3);
    wait_done(40, 0);
    chk("starve_count", deliv, 3);

    // zero length, then an ignored second start
    start(4'd0);
    chk("zero_done", done_o, 1);
    wait_done(5, 0);
    for (int i = 0; i < 5; i++) push(8'($urandom));
    start(4'd5);
    @(posedge clk); #1;
    start(4'd3);
    wait_done(40, 0);
    chk("ignored_count", deliv, 5);

    // reset mid-burst; undelivered words are dropped, FIFO is not rewound
    for (int i = 0; i < 8; i++) push(8'($urandom));
    m_ready_i = 1'b0;
    start(4'd8);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", m_valid_o, 0);
    chk("rst_mid_rem", remaining_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_pop", fifo_rd_valid_o, 0);
    m_ready_i = 1'b1;
    start(4'd6);
    wait_done(40, 0);
    chk("post_rst_count", deliv, 6);
    chk("post_rst_drained", rd_ptr, wr_ptr);

    // max length
    for (int i = 0; i < 15; i++) push(8'(i));
    start(4'd15);
    wait_done(60, 0);
    chk("max_count", deliv, 15);

    // random bursts with random backpressure and starvation
    for (int b = 0; b < 20; b++) begin
      len = LW'($urandom_range(0, 15));
      for (int i = 0; i < int'(len); i++) push(8'($urandom));
      start(len);
      wait_done(300, 1);
      chk("rand_count", deliv, int'(len));
    end
    chk("fifo_drained", rd_ptr, wr_ptr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
